// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the fetch PC sequencer.
//   pc_state_e        - sequencer state: BOOT, RUN, PENDING
//   RESET_PC_DEFAULT  - default PC loaded on reset
//   PC_INCR           - sequential fetch increment (one 32-bit instruction)
//   form_jump_target  - J/JAL target from PC+4 region bits and the index field
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    // The jump stays inside the 256 MB region of the delay-slot instruction.
    function automatic logic [31:0] form_jump_target(input logic [31:0] pc_plus_four,
                                                     input logic [25:0] raw_address);
        return {pc_plus_four[31:28], raw_address, 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_select.sv
// pc_redirect_select: combinational priority select among redirect sources.
// Priority is branch > jr > jump; losing requests are dropped.
// Ports:
//   jump_valid_i, jump_raw_address_i, jump_pc_plus_four_i - J/JAL request
//   jr_valid_i, jr_target_i                               - JR/JALR request
//   branch_valid_i, branch_target_i                       - taken branch
//   redirect_valid_o    - any request present
//   redirect_target_o   - winning target, word aligned
//   jr_misaligned_o     - winner is jr and its target had bits [1:0] set
module pc_redirect_select
    import pc_seq_pkg::*;
(
    input  logic        jump_valid_i,
    input  logic [25:0] jump_raw_address_i,
    input  logic [31:0] jump_pc_plus_four_i,
    input  logic        jr_valid_i,
    input  logic [31:0] jr_target_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_target_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_target_o,
    output logic        jr_misaligned_o
);

    always_comb begin
        redirect_valid_o  = branch_valid_i | jr_valid_i | jump_valid_i;
        redirect_target_o = form_jump_target(jump_pc_plus_four_i, jump_raw_address_i);
        jr_misaligned_o   = 1'b0;
        if (branch_valid_i) begin
            redirect_target_o = branch_target_i;
        end else if (jr_valid_i) begin
            // Misaligned register targets are still taken, forced to a word boundary.
            redirect_target_o = {jr_target_i[31:2], 2'b00};
            jr_misaligned_o   = (jr_target_i[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and sequences it (PC+4 or redirect).
// Build option: define PC_SEQ_DELAY_SLOT_EN for MIPS delay-slot behaviour
// (flush never asserted); otherwise flush kills the instruction in fetch in
// the cycle a redirect is applied to pc.
// Handshake: redirect inputs are single-cycle pulses sampled on the rising
// edge; there is no back-pressure to decode. A redirect arriving while one is
// already pending is dropped and recorded in the sticky redirect_error.
// Ports:
//   clock, reset_n       - clock, asynchronous active-low reset
//   stall                - hold pc
//   jump_* / jr_* / branch_* - redirect requests from decode
//   pc, pc_plus_four     - current fetch address and its successor
//   fetch_valid          - fetch at pc is a real instruction
//   flush                - kill the instruction in fetch
//   addr_error           - pulse: accepted jr target was misaligned
//   redirect_error       - sticky: redirect dropped while pending
//   state_dbg            - current FSM state (pc_state_e encoding)
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          PC_WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                jump_valid,
    input  logic [25:0]         jump_raw_address,
    input  logic [PC_WIDTH-1:0] jump_pc_plus_four,
    input  logic                jr_valid,
    input  logic [PC_WIDTH-1:0] jr_target,
    input  logic                branch_valid,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus_four,
    output logic                fetch_valid,
    output logic                flush,
    output logic                addr_error,
    output logic                redirect_error,
    output logic [1:0]          state_dbg
);

    pc_state_e           state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pending_target_q;
    logic                redirect_error_q;

    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                jr_misaligned;

    pc_redirect_select u_select (
        .jump_valid_i        (jump_valid),
        .jump_raw_address_i  (jump_raw_address),
        .jump_pc_plus_four_i (jump_pc_plus_four),
        .jr_valid_i          (jr_valid),
        .jr_target_i         (jr_target),
        .branch_valid_i      (branch_valid),
        .branch_target_i     (branch_target),
        .redirect_valid_o    (redirect_valid),
        .redirect_target_o   (redirect_target),
        .jr_misaligned_o     (jr_misaligned)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= BOOT;
            pc_q             <= RESET_PC;
            pending_target_q <= '0;
            redirect_error_q <= 1'b0;
        end else begin
            case (state_q)
                // Redirects seen during BOOT are dropped; pc is unchanged.
                BOOT: state_q <= RUN;
                RUN: begin
                    if (redirect_valid) begin
                        if (stall) begin
                            pending_target_q <= redirect_target;
                            state_q          <= PENDING;
                        end else begin
                            pc_q <= redirect_target;
                        end
                    end else if (!stall) begin
                        pc_q <= pc_q + PC_INCR;  // wraps at 2^32
                    end
                end
                PENDING: begin
                    if (redirect_valid) begin
                        redirect_error_q <= 1'b1;
                    end
                    if (!stall) begin
                        pc_q    <= pending_target_q;
                        state_q <= RUN;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign pc             = pc_q;
    assign pc_plus_four   = pc_q + PC_INCR;
    assign fetch_valid    = (state_q != BOOT) && !stall;
    assign addr_error     = (state_q == RUN) && redirect_valid && jr_misaligned;
    assign redirect_error = redirect_error_q;
    assign state_dbg      = state_q;

`ifdef PC_SEQ_DELAY_SLOT_EN
    // The instruction in fetch is the delay slot and must execute.
    assign flush = 1'b0;
`else
    // Flush coincides with the cycle whose closing edge loads the new pc.
    assign flush = !stall && (((state_q == RUN) && redirect_valid) || (state_q == PENDING));
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_PEND = 2;

  // ---------------- clock / reset ----------------
  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        jump_valid;
  logic [25:0] jump_raw_address;
  logic [31:0] jump_pc_plus_four;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] pc_plus_four;
  logic        fetch_valid;
  logic        flush;
  logic        addr_error;
  logic        redirect_error;
  logic [1:0]  state_dbg;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  pc_sequencer #(.RESET_PC(RST_PC), .PC_WIDTH(32)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .stall             (stall),
    .jump_valid        (jump_valid),
    .jump_raw_address  (jump_raw_address),
    .jump_pc_plus_four (jump_pc_plus_four),
    .jr_valid          (jr_valid),
    .jr_target         (jr_target),
    .branch_valid      (branch_valid),
    .branch_target     (branch_target),
    .pc                (pc),
    .pc_plus_four      (pc_plus_four),
    .fetch_valid       (fetch_valid),
    .flush             (flush),
    .addr_error        (addr_error),
    .redirect_error    (redirect_error),
    .state_dbg         (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [69:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;

  // reference model: mode, pc, latched target, sticky error
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic        m_err;

  function automatic logic [69:0] pack(input logic [31:0] p, input logic [31:0] ppf,
                                       input logic fv, input logic fl, input logic ae,
                                       input logic re, input logic [1:0] s);
    return {p, ppf, fv, fl, ae, re, s};
  endfunction

  function automatic logic [1:0] mode_code(input int mode);
    pc_state_e s;
    if (mode == M_BOOT) s = BOOT;
    else if (mode == M_RUN) s = RUN;
    else s = PENDING;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic st, input logic jv, input logic [25:0] raw,
                             input logic [31:0] jppf, input logic jrv, input logic [31:0] jrt,
                             input logic bv, input logic [31:0] bt);
    logic        req;
    logic [31:0] tgt;
    logic        jr_bad;
    logic        fv, fl, ae;
    int          n_mode;
    logic [31:0] n_pc, n_pend;
    logic        n_err;
    stall = st; jump_valid = jv; jump_raw_address = raw; jump_pc_plus_four = jppf;
    jr_valid = jrv; jr_target = jrt; branch_valid = bv; branch_target = bt;

    req = bv | jrv | jv;
    if (bv) tgt = bt;
    else if (jrv) tgt = jrt & 32'hFFFF_FFFC;
    else tgt = (jppf & 32'hF000_0000) | ({6'd0, raw} << 2);
    jr_bad = !bv && jrv && (jrt[1:0] != 2'b00);

    fv = (m_mode != M_BOOT) && !st;
    fl = 1'b0; ae = 1'b0;
    n_mode = m_mode; n_pc = m_pc; n_pend = m_pend; n_err = m_err;
    if (m_mode == M_BOOT) begin
      n_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (req) begin
        ae = jr_bad;
        if (st) begin n_pend = tgt; n_mode = M_PEND; end
        else begin n_pc = tgt; fl = 1'b1; end
      end else if (!st) begin
        n_pc = m_pc + 32'd4;
      end
    end else begin
      if (req) n_err = 1'b1;
      if (!st) begin n_pc = m_pend; n_mode = M_RUN; fl = 1'b1; end
    end
`ifdef PC_SEQ_DELAY_SLOT_EN
    fl = 1'b0;
`endif
    exp_q.push_back(pack(m_pc, m_pc + 32'd4, fv, fl, ae, m_err, mode_code(m_mode)));
    pushes++;
    m_mode = n_mode; m_pc = n_pc; m_pend = n_pend; m_err = n_err;
    @(posedge clock); #1;
  endtask

  task automatic idle(input logic st);
    drive_cycle(st, 1'b0, 26'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic branch(input logic st, input logic [31:0] bt);
    drive_cycle(st, 1'b0, 26'd0, 32'd0, 1'b0, 32'd0, 1'b1, bt);
  endtask

  // Assert reset for one edge; reset values are visible during it.
  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0; jump_valid = 1'b0; jr_valid = 1'b0; branch_valid = 1'b0;
    m_mode = M_BOOT; m_pc = RST_PC; m_pend = 32'd0; m_err = 1'b0;
    exp_q.push_back(pack(RST_PC, RST_PC + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, mode_code(M_BOOT)));
    pushes++;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic check_const(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [69:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pops++;
      a = pack(pc, pc_plus_four, fetch_valid, flush, addr_error, redirect_error, state_dbg);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got pc=%h ppf=%h fv=%b fl=%b ae=%b re=%b st=%0d expected pc=%h ppf=%h fv=%b fl=%b ae=%b re=%b st=%0d",
                 $time, a[69:38], a[37:6], a[5], a[4], a[3], a[2], a[1:0],
                 e[69:38], e[37:6], e[5], e[4], e[3], e[2], e[1:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    stall = 1'b0; jump_valid = 1'b0; jump_raw_address = '0; jump_pc_plus_four = '0;
    jr_valid = 1'b0; jr_target = '0; branch_valid = 1'b0; branch_target = '0;
    m_mode = M_BOOT; m_pc = RST_PC; m_pend = 32'd0; m_err = 1'b0;
    @(posedge clock); #1;

    // 1: boot then sequential fetch
    do_reset();
    check_const("reset_pc", pc, RST_PC);
    repeat (4) idle(1'b0);
    check_const("seq_pc", pc, 32'hBFC0_000C);

    // 2: jump target formation
    branch(1'b0, 32'h0040_0010);
    check_const("branch_pc", pc, 32'h0040_0010);
    drive_cycle(1'b0, 1'b1, 26'h0100000, 32'h0040_0010, 1'b0, 32'd0, 1'b0, 32'd0);
    check_const("jump_pc", pc, 32'h0040_0000);

    // 3: branch beats jump
    drive_cycle(1'b0, 1'b1, 26'h0000123, 32'h0040_0004, 1'b0, 32'd0, 1'b1, 32'h0000_1000);
    check_const("prio_pc", pc, 32'h0000_1000);

    // 4: misaligned jr while stalled, then release
    drive_cycle(1'b1, 1'b0, 26'd0, 32'd0, 1'b1, 32'h0000_2003, 1'b0, 32'd0);
    check_const("pend_state", {30'd0, state_dbg}, {30'd0, 2'(PENDING)});
    check_const("pend_pc_hold", pc, 32'h0000_1000);
    repeat (3) idle(1'b1);
    idle(1'b0);
    check_const("jr_pc", pc, 32'h0000_2000);

    // 5: second redirect while pending
    branch(1'b1, 32'h0000_3000);
    branch(1'b1, 32'h0000_4000);
    idle(1'b0);
    check_const("pend_first_wins", pc, 32'h0000_3000);
    check_const("redir_err_set", {31'd0, redirect_error}, 32'd1);
    repeat (3) idle(1'b0);
    check_const("redir_err_sticky", {31'd0, redirect_error}, 32'd1);
    do_reset();
    check_const("redir_err_clr", {31'd0, redirect_error}, 32'd0);
    idle(1'b0);

    // 6: wrap and reset mid-PENDING
    branch(1'b0, 32'hFFFF_FFFC);
    idle(1'b0);
    check_const("wrap_pc", pc, 32'h0000_0000);
    branch(1'b1, 32'h0000_5000);
    do_reset();
    check_const("rst_pend_pc", pc, RST_PC);
    check_const("rst_pend_state", {30'd0, state_dbg}, {30'd0, 2'(BOOT)});
    repeat (2) idle(1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        logic [31:0] bt;
        bt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        drive_cycle($urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0, 26'($urandom), $urandom,
                    $urandom_range(0, 5) == 0, $urandom,
                    $urandom_range(0, 6) == 0, bt);
      end
    end

    idle(1'b0);
    repeat (2) @(posedge clock);
    checks++;
    if (pops != pushes) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d popped expected %0d", pops, pushes);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
